hash_request_sequencer: RTL and testbench
=========================================

Name: hash_request_sequencer

Overview:
- Initiator-side front end for the hash-table controller. Accepts single key/data requests (read, write, delete, nop) on a valid/ready handshake.
- Holds the key stable and waits out the table read latency, then presents the operation code to the controller for exactly one cycle.
- Samples the controller's data and status flags in that cycle and returns a response on a second valid/ready handshake.
- Serialises all table accesses: one request in flight.

Parameters:
- KEY_WIDTH, 2, key width in bits.
- DATA_WIDTH, 32, data payload width in bits.
- READ_LATENCY, 1, cycles from mem_rd_en_o until table read-out is valid at the controller; legal range 0..15.

Ports:
- clk  in  1  clock; all logic is rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  sequencer can accept a request.
- req_op_i  in  2  00 nop, 01 read, 10 write, 11 delete.
- req_key_i  in  KEY_WIDTH  request key.
- req_data_i  in  DATA_WIDTH  write data; ignored for other ops.
- mem_rd_en_o  out  1  one-cycle pulse starting the table read for ctrl_key_o.
- ctrl_key_o  out  KEY_WIDTH  key to controller and hash units.
- ctrl_data_o  out  DATA_WIDTH  data to controller.
- ctrl_op_o  out  2  operation to controller; 00 except in EXEC.
- ctrl_read_data_i  in  DATA_WIDTH  controller read data.
- ctrl_no_element_found_i  in  1  controller flag.
- ctrl_no_write_space_i  in  1  controller flag.
- ctrl_no_deletion_target_i  in  1  controller flag.
- resp_valid_o  out  1  response valid.
- resp_ready_i  in  1  consumer accepts response.
- resp_op_o  out  2  op being answered.
- resp_data_o  out  DATA_WIDTH  read result; 0 for every other op and for a failed read.
- resp_status_o  out  2  00 OK, 01 NOT_FOUND, 10 NO_SPACE, 11 NO_DEL_TARGET.

Behaviour:
- Reset values (asynchronous, immediate on rst_n low):
  - State IDLE; req_ready_o=1.
  - resp_valid_o=0, mem_rd_en_o=0, ctrl_op_o=00.
  - ctrl_key_o, ctrl_data_o, resp_op_o, resp_data_o and resp_status_o all 0.
- State machine: IDLE, READ_WAIT, EXEC, RESP.
- IDLE:
  - req_ready_o=1.
  - On req_valid_i && req_ready_o, register op, key and data into ctrl_*.
  - nop goes to RESP with status OK and data 0.
  - Any other op with READ_LATENCY>0 goes to READ_WAIT with mem_rd_en_o=1 in the first READ_WAIT cycle. With READ_LATENCY=0 it goes to EXEC and mem_rd_en_o=1 during EXEC.
- READ_WAIT: 4-bit down-counter loaded with READ_LATENCY-1; move to EXEC when it reaches 0. ctrl_op_o=00.
- EXEC:
  - Exactly one cycle with ctrl_op_o equal to the registered op. Table writes and deletes commit on the closing edge.
  - Sample status:
    - read: NOT_FOUND if ctrl_no_element_found_i, else OK with resp_data_o=ctrl_read_data_i.
    - write: NO_SPACE if ctrl_no_write_space_i, else OK.
    - delete: NO_DEL_TARGET if ctrl_no_deletion_target_i, else OK.
  - Then go to RESP.
- RESP:
  - resp_valid_o=1; all resp_* held stable until resp_valid_o && resp_ready_i.
  - On that handshake, go to IDLE.
- Handshake rules:
  - req_ready_o=0 outside IDLE.
  - Latency from the acceptance edge to resp_valid_o is READ_LATENCY+2 cycles for non-nop ops and 1 cycle for nop.
  - One transaction is in flight at a time; throughput is one op per READ_LATENCY+3 cycles with resp_ready_i held high.
- ctrl_key_o and ctrl_data_o are held constant from acceptance until the return to IDLE.
- Back-to-back: a request is never accepted in the same cycle a response is taken. The next acceptance is at the earliest one cycle later, in IDLE.
- Reset mid-operation:
  - The in-flight op is dropped and no response is produced.
  - Reset asserted during EXEC: whether the table commit happened is undefined; the bench must not check it.

Optional Feature:
- Macro HASH_SEQ_STATS_EN.
- Defined:
  - Adds outputs stat_ops_o[15:0] and stat_fail_o[15:0].
  - stat_ops_o counts completed response handshakes, nop included.
  - stat_fail_o counts completed handshakes with status≠OK.
  - Both are saturating at 16'hFFFF and reset to 0.
- Undefined: neither port nor counter exists.

Decomposition:
- Package hash_table_pkg:
  - op codes NOTHING/READ/WRITE/DELETE (2-bit);
  - status enum OK/NOT_FOUND/NO_SPACE/NO_DEL_TARGET;
  - FSM state enum.
- Sub-module sat_counter (WIDTH parameter, inc input, saturating) is instantiated only under HASH_SEQ_STATS_EN.

Test Plan:
- Reset: hold rst_n=0 mid-run → req_ready_o=1, resp_valid_o=0, ctrl_op_o=00, mem_rd_en_o=0 immediately.
- Write key 2'b01, data 32'hDEADBEEF, flags 0, READ_LATENCY=1:
  - mem_rd_en_o pulses cycle 1, ctrl_op_o=10 only in cycle 2, resp_valid_o in cycle 3;
  - response status 00, data 0, op 10.
- Read key 2'b01, ctrl_read_data_i=32'hDEADBEEF → status 00, data DEADBEEF. Repeat with ctrl_no_element_found_i=1 → status 01, data 0.
- Write with ctrl_no_write_space_i=1 → status 10. Delete with ctrl_no_deletion_target_i=1 → status 11.
- resp_ready_i=0 for 5 cycles with req_valid_i=1 → resp_* stable, req_ready_o=0, second request accepted only after the response handshake.
- rst_n pulsed low during READ_WAIT → IDLE, ctrl_op_o never nonzero, no response. With HASH_SEQ_STATS_EN, 3 ops of which 1 fails → stat_ops_o=3, stat_fail_o=1.

Source files
------------

// File: rtl/hash_table_pkg.sv
// Shared types for the hash-table front end: op codes, response status,
// sequencer FSM states and the status decode used in the execute cycle.
package hash_table_pkg;

    typedef enum logic [1:0] {
        NOTHING = 2'b00,
        READ    = 2'b01,
        WRITE   = 2'b10,
        DELETE  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        OK            = 2'b00,
        NOT_FOUND     = 2'b01,
        NO_SPACE      = 2'b10,
        NO_DEL_TARGET = 2'b11
    } status_e;

    typedef enum logic [1:0] {
        IDLE,
        READ_WAIT,
        EXEC,
        RESP
    } state_e;

    // Read-latency down-counter width; covers READ_LATENCY up to 15.
    localparam int CNT_W = 4;

    // Each op only looks at the controller flag that concerns it.
    function automatic status_e exec_status(input op_e op, input logic no_found,
                                            input logic no_space, input logic no_del);
        case (op)
            READ:    return no_found ? NOT_FOUND     : OK;
            WRITE:   return no_space ? NO_SPACE      : OK;
            DELETE:  return no_del   ? NO_DEL_TARGET : OK;
            default: return OK;
        endcase
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Free-running event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    // Count one per inc pulse, holding at the maximum value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else if (inc && (count != {WIDTH{1'b1}}))
            count <= count + 1'b1;
    end

endmodule

// File: rtl/hash_request_sequencer.sv
// Initiator-side front end for the hash-table controller. Accepts one
// request at a time, waits out the table read latency, drives the op to the
// controller for a single cycle and returns the sampled result.
// Optional: define HASH_SEQ_STATS_EN to add response/failure counters.
module hash_request_sequencer
    import hash_table_pkg::*;
#(
    parameter int KEY_WIDTH    = 2,
    parameter int DATA_WIDTH   = 32,
    parameter int READ_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [1:0]            req_op_i,
    input  logic [KEY_WIDTH-1:0]  req_key_i,
    input  logic [DATA_WIDTH-1:0] req_data_i,
    output logic                  mem_rd_en_o,
    output logic [KEY_WIDTH-1:0]  ctrl_key_o,
    output logic [DATA_WIDTH-1:0] ctrl_data_o,
    output logic [1:0]            ctrl_op_o,
    input  logic [DATA_WIDTH-1:0] ctrl_read_data_i,
    input  logic                  ctrl_no_element_found_i,
    input  logic                  ctrl_no_write_space_i,
    input  logic                  ctrl_no_deletion_target_i,
    output logic                  resp_valid_o,
    input  logic                  resp_ready_i,
    output logic [1:0]            resp_op_o,
    output logic [DATA_WIDTH-1:0] resp_data_o,
    output logic [1:0]            resp_status_o
`ifdef HASH_SEQ_STATS_EN
   ,output logic [15:0]           stat_ops_o,
    output logic [15:0]           stat_fail_o
`endif
);

    // READ_WAIT lasts READ_LATENCY cycles: counter runs LOAD..0.
    localparam logic [CNT_W-1:0] RW_LOAD =
        CNT_W'((READ_LATENCY > 0) ? READ_LATENCY - 1 : 0);

    state_e           state_q, state_d;
    op_e              op_q;
    logic [CNT_W-1:0] cnt_q;
    logic             accept;
    op_e              req_op;

    assign req_op = op_e'(req_op_i);
    assign accept = (state_q == IDLE) && req_valid_i;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // Next-state and the purely state-derived handshake/control outputs.
    always_comb begin
        state_d      = state_q;
        req_ready_o  = 1'b0;
        resp_valid_o = 1'b0;
        ctrl_op_o    = NOTHING;
        case (state_q)
            IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    if (req_op == NOTHING)
                        state_d = RESP;
                    else if (READ_LATENCY == 0)
                        state_d = EXEC;
                    else
                        state_d = READ_WAIT;
                end
            end
            READ_WAIT: begin
                if (cnt_q == '0)
                    state_d = EXEC;
            end
            EXEC: begin
                ctrl_op_o = op_q;
                state_d   = RESP;
            end
            RESP: begin
                resp_valid_o = 1'b1;
                if (resp_ready_i)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Request capture, latency counter, read strobe and response capture.
    // mem_rd_en_o is set on the acceptance edge, so it lands in the first
    // READ_WAIT cycle, or in EXEC itself when there is no read latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q          <= NOTHING;
            cnt_q         <= '0;
            mem_rd_en_o   <= 1'b0;
            ctrl_key_o    <= '0;
            ctrl_data_o   <= '0;
            resp_op_o     <= '0;
            resp_data_o   <= '0;
            resp_status_o <= '0;
        end else begin
            mem_rd_en_o <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        op_q        <= req_op;
                        ctrl_key_o  <= req_key_i;
                        ctrl_data_o <= req_data_i;
                        cnt_q       <= RW_LOAD;
                        mem_rd_en_o <= (req_op != NOTHING);
                        // A nop skips the controller entirely.
                        if (req_op == NOTHING) begin
                            resp_op_o     <= NOTHING;
                            resp_data_o   <= '0;
                            resp_status_o <= OK;
                        end
                    end
                end
                READ_WAIT: begin
                    if (cnt_q != '0)
                        cnt_q <= cnt_q - 1'b1;
                end
                EXEC: begin
                    resp_op_o     <= op_q;
                    resp_status_o <= exec_status(op_q, ctrl_no_element_found_i,
                                                 ctrl_no_write_space_i,
                                                 ctrl_no_deletion_target_i);
                    resp_data_o   <= (op_q == READ && !ctrl_no_element_found_i)
                                     ? ctrl_read_data_i : '0;
                end
                default: ;
            endcase
        end
    end

`ifdef HASH_SEQ_STATS_EN
    logic resp_fire;
    assign resp_fire = resp_valid_o && resp_ready_i;

    sat_counter #(.WIDTH(16)) u_stat_ops (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (resp_fire),
        .count (stat_ops_o)
    );

    sat_counter #(.WIDTH(16)) u_stat_fail (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (resp_fire && (resp_status_o != OK)),
        .count (stat_fail_o)
    );
`endif

endmodule

// File: tb/tb_hash_request_sequencer.sv
// Self-checking bench for hash_request_sequencer: directed table, randomized
// transactions against a behavioural model, and multi-cycle corner sequences.
module tb_hash_request_sequencer;

    localparam int KW = 2;
    localparam int DW = 32;
    localparam int RL = 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [1:0]    req_op = '0;
    logic [KW-1:0] req_key = '0;
    logic [DW-1:0] req_data = '0;
    logic          mem_rd_en;
    logic [KW-1:0] ctrl_key;
    logic [DW-1:0] ctrl_data;
    logic [1:0]    ctrl_op;
    logic [DW-1:0] rd_data = '0;
    logic          nf = 1'b0, ns = 1'b0, nd = 1'b0;
    logic          resp_valid;
    logic          resp_ready = 1'b1;
    logic [1:0]    resp_op;
    logic [DW-1:0] resp_data;
    logic [1:0]    resp_status;
`ifdef HASH_SEQ_STATS_EN
    logic [15:0]   stat_ops, stat_fail;
`endif

    int checks = 0;
    int errors = 0;

    hash_request_sequencer #(.KEY_WIDTH(KW), .DATA_WIDTH(DW), .READ_LATENCY(RL)) dut (
        .clk                       (clk),
        .rst_n                     (rst_n),
        .req_valid_i               (req_valid),
        .req_ready_o               (req_ready),
        .req_op_i                  (req_op),
        .req_key_i                 (req_key),
        .req_data_i                (req_data),
        .mem_rd_en_o               (mem_rd_en),
        .ctrl_key_o                (ctrl_key),
        .ctrl_data_o               (ctrl_data),
        .ctrl_op_o                 (ctrl_op),
        .ctrl_read_data_i          (rd_data),
        .ctrl_no_element_found_i   (nf),
        .ctrl_no_write_space_i     (ns),
        .ctrl_no_deletion_target_i (nd),
        .resp_valid_o              (resp_valid),
        .resp_ready_i              (resp_ready),
        .resp_op_o                 (resp_op),
        .resp_data_o               (resp_data),
        .resp_status_o             (resp_status)
`ifdef HASH_SEQ_STATS_EN
       ,.stat_ops_o                (stat_ops),
        .stat_fail_o               (stat_fail)
`endif
    );

    always #5 clk = ~clk;

    // Watchdog over a window: ctrl_op must stay 0 and no response may appear.
    bit mon_en = 1'b0;
    int bad_op = 0, bad_resp = 0;
    always @(negedge clk) begin
        if (mon_en) begin
            if (ctrl_op != 2'b00) bad_op++;
            if (resp_valid) bad_resp++;
        end
    end

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    // Spec-level result of an op given the controller's flags {nf,ns,nd}.
    function automatic void model(input logic [1:0] op, input logic [31:0] rd,
                                  input logic [2:0] fl, output logic [31:0] d,
                                  output logic [1:0] st);
        d = '0; st = 2'b00;
        case (op)
            2'b01: if (fl[2]) st = 2'b01; else d = rd;
            2'b10: if (fl[1]) st = 2'b10;
            2'b11: if (fl[0]) st = 2'b11;
            default: ;
        endcase
    endfunction

    // One complete transaction with timing checks; stall = cycles of resp backpressure.
    task automatic run_txn(input string nm, input logic [1:0] op, input logic [1:0] key,
                           input logic [31:0] wd, input logic [31:0] rd, input logic [2:0] fl,
                           input logic [1:0] e_op, input logic [31:0] e_data,
                           input logic [1:0] e_st, input int stall);
        int cyc = 0, rd_cnt = 0, rd_cyc = -1, op_cnt = 0, op_cyc = -1;
        logic [1:0] op_seen = 2'b00;
        bit done = 1'b0, hold_ok = 1'b1, stable = 1'b1;
        logic [1:0] c_op, c_st;
        logic [31:0] c_data;
        @(negedge clk);
        req_valid = 1'b1; req_op = op; req_key = key; req_data = wd;
        rd_data = rd; {nf, ns, nd} = fl; resp_ready = 1'b1;
        chk({nm, ".ready"}, req_ready, 1);
        @(posedge clk);
        while (!done && cyc < 40) begin
            @(negedge clk);
            cyc++;
            req_valid = 1'b0;
            if (mem_rd_en) begin rd_cnt++; rd_cyc = cyc; end
            if (ctrl_op != 2'b00) begin op_cnt++; op_cyc = cyc; op_seen = ctrl_op; end
            if (ctrl_key !== key || ctrl_data !== wd) hold_ok = 1'b0;
            if (resp_valid) done = 1'b1;
        end
        chk({nm, ".resp_seen"}, done, 1);
        chk({nm, ".latency"}, cyc, (op == 2'b00) ? 1 : RL + 2);
        chk({nm, ".rd_en_cnt"}, rd_cnt, (op == 2'b00) ? 0 : 1);
        chk({nm, ".rd_en_cyc"}, rd_cyc, (op == 2'b00) ? -1 : 1);
        chk({nm, ".ctrl_op_cnt"}, op_cnt, (op == 2'b00) ? 0 : 1);
        chk({nm, ".ctrl_op_cyc"}, op_cyc, (op == 2'b00) ? -1 : RL + 1);
        chk({nm, ".ctrl_op_val"}, op_seen, op);
        chk({nm, ".key_data_held"}, hold_ok, 1);
        chk({nm, ".resp_op"}, resp_op, e_op);
        chk({nm, ".resp_data"}, resp_data, e_data);
        chk({nm, ".resp_status"}, resp_status, e_st);
        if (stall > 0) begin
            c_op = resp_op; c_data = resp_data; c_st = resp_status;
            resp_ready = 1'b0;
            for (int s = 0; s < stall; s++) begin
                @(negedge clk);
                if (!resp_valid || req_ready || resp_op !== c_op ||
                    resp_data !== c_data || resp_status !== c_st) stable = 1'b0;
            end
            chk({nm, ".stall_stable"}, stable, 1);
            resp_ready = 1'b1;
        end
        @(posedge clk);
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [1:0]  key;
        logic [31:0] wd;
        logic [31:0] rd;
        logic [2:0]  fl;
        logic [1:0]  e_op;
        logic [31:0] e_data;
        logic [1:0]  e_st;
    } vec_t;

    vec_t tbl[8];

    initial begin
        logic [1:0]  r_op, r_key, r_st;
        logic [31:0] r_wd, r_rd, r_d;
        logic [2:0]  r_fl;
        logic [1:0]  cap_op, cap_st;
        logic [31:0] cap_data;
        int          w;
        bit          stable;

        tbl[0] = '{2'b10, 2'b01, 32'hDEADBEEF, 32'h0,        3'b000, 2'b10, 32'h0,        2'b00};
        tbl[1] = '{2'b01, 2'b01, 32'h0,        32'hDEADBEEF, 3'b000, 2'b01, 32'hDEADBEEF, 2'b00};
        tbl[2] = '{2'b01, 2'b01, 32'h0,        32'hDEADBEEF, 3'b100, 2'b01, 32'h0,        2'b01};
        tbl[3] = '{2'b10, 2'b10, 32'h12345678, 32'h0,        3'b010, 2'b10, 32'h0,        2'b10};
        tbl[4] = '{2'b11, 2'b11, 32'h0,        32'h0,        3'b001, 2'b11, 32'h0,        2'b11};
        tbl[5] = '{2'b11, 2'b00, 32'h0,        32'hFFFFFFFF, 3'b110, 2'b11, 32'h0,        2'b00};
        tbl[6] = '{2'b00, 2'b10, 32'hCAFEF00D, 32'h55AA55AA, 3'b111, 2'b00, 32'h0,        2'b00};
        tbl[7] = '{2'b01, 2'b11, 32'h0,        32'h0BADF00D, 3'b011, 2'b01, 32'h0BADF00D, 2'b00};

        // Reset state.
        #1;
        chk("rst.ready", req_ready, 1);
        chk("rst.resp_valid", resp_valid, 0);
        chk("rst.mem_rd_en", mem_rd_en, 0);
        chk("rst.ctrl_op", ctrl_op, 0);
        chk("rst.ctrl_key_data", {ctrl_key, ctrl_data}, 0);
        chk("rst.resp_fields", {resp_op, resp_data, resp_status}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Directed table.
        for (int i = 0; i < 8; i++)
            run_txn($sformatf("vec%0d", i), tbl[i].op, tbl[i].key, tbl[i].wd, tbl[i].rd,
                    tbl[i].fl, tbl[i].e_op, tbl[i].e_data, tbl[i].e_st, 0);

        // Randomized ops against the model, with occasional response backpressure.
        for (int i = 0; i < 40; i++) begin
            r_op = 2'($urandom_range(0, 3));
            r_key = 2'($urandom_range(0, 3));
            r_wd = $urandom; r_rd = $urandom;
            r_fl = 3'($urandom_range(0, 7));
            model(r_op, r_rd, r_fl, r_d, r_st);
            run_txn($sformatf("rnd%0d", i), r_op, r_key, r_wd, r_rd, r_fl, r_op, r_d, r_st,
                    int'($urandom_range(0, 2)));
        end

        // Backpressure: first response held 5 cycles while a second request waits.
        @(negedge clk);
        req_valid = 1'b1; req_op = 2'b10; req_key = 2'b10; req_data = 32'hA5A5A5A5;
        {nf, ns, nd} = 3'b000; resp_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        req_op = 2'b01; req_key = 2'b11; req_data = 32'h0; rd_data = 32'h00001234;
        w = 0;
        while (!resp_valid && w < 20) begin @(negedge clk); w++; end
        chk("bp.resp_seen", resp_valid, 1);
        cap_op = resp_op; cap_data = resp_data; cap_st = resp_status;
        chk("bp.first_resp", {cap_op, cap_data, cap_st}, {2'b10, 32'h0, 2'b00});
        stable = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (!resp_valid || req_ready || mem_rd_en || resp_op !== cap_op ||
                resp_data !== cap_data || resp_status !== cap_st) stable = 1'b0;
        end
        chk("bp.held_stable", stable, 1);
        resp_ready = 1'b1;
        @(negedge clk);
        chk("bp.idle_after_hs", {resp_valid, req_ready, mem_rd_en}, 3'b010);
        chk("bp.key_before_accept", ctrl_key, 2'b10);
        @(negedge clk);
        req_valid = 1'b0;
        chk("bp.second_accepted", {req_ready, mem_rd_en}, 2'b01);
        chk("bp.second_key", ctrl_key, 2'b11);
        w = 0;
        while (!resp_valid && w < 20) begin @(negedge clk); w++; end
        chk("bp.second_resp", {resp_valid, resp_op, resp_data, resp_status},
            {1'b1, 2'b01, 32'h00001234, 2'b00});
        @(posedge clk);

        // Reset pulsed during READ_WAIT: op dropped, nothing reaches the controller.
        @(negedge clk);
        req_valid = 1'b1; req_op = 2'b11; req_key = 2'b01; {nf, ns, nd} = 3'b000;
        @(posedge clk);
        bad_op = 0; bad_resp = 0; mon_en = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        chk("rstmid.in_read_wait", {mem_rd_en, req_ready}, 2'b10);
        rst_n = 1'b0;
        #1;
        chk("rstmid.ready", req_ready, 1);
        chk("rstmid.resp_valid", resp_valid, 0);
        chk("rstmid.ctrl_op", ctrl_op, 0);
        chk("rstmid.mem_rd_en", mem_rd_en, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        mon_en = 1'b0;
        chk("rstmid.ctrl_op_never", bad_op, 0);
        chk("rstmid.no_resp", bad_resp, 0);
        chk("rstmid.idle", req_ready, 1);

`ifdef HASH_SEQ_STATS_EN
        chk("stats.cleared", {stat_ops, stat_fail}, 32'h0);
        run_txn("stats.w", 2'b10, 2'b00, 32'h1, 32'h0, 3'b000, 2'b10, 32'h0, 2'b00, 0);
        run_txn("stats.r", 2'b01, 2'b00, 32'h0, 32'h7, 3'b100, 2'b01, 32'h0, 2'b01, 0);
        run_txn("stats.n", 2'b00, 2'b00, 32'h0, 32'h0, 3'b000, 2'b00, 32'h0, 2'b00, 0);
        @(negedge clk);
        chk("stats.ops", stat_ops, 3);
        chk("stats.fail", stat_fail, 1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
